// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file: selects the writeback value, commits it,
// serves two bypassed decode read ports and streams all registers to the debug unit on request.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_output_mem,
  input  logic [DATA_W-1:0] i_ALU_res,
  input  logic [DATA_W-1:0] i_pc_to_reg,
  input  logic [ADDR_W-1:0] i_addr_reg_dst,
  input  logic              is_RegWrite,
  input  logic              is_MemtoReg,
  input  logic              is_write_pc,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_dump_req,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_done
);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_st_t;

  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic                         wr_en;
  dump_st_t                     st, st_nxt;
  logic [ADDR_W-1:0]            idx, idx_nxt;

  assign o_wb_data = is_write_pc ? i_pc_to_reg
                   : is_MemtoReg ? i_output_mem : i_ALU_res;

  // Register 0 is never written, so it reads back as zero everywhere, dump included.
  assign wr_en = i_step & is_RegWrite & (i_addr_reg_dst != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       regs <= '0;
    else if (wr_en) regs[i_addr_reg_dst] <= o_wb_data;
  end

  // Write-before-read: a same-cycle write is visible on the decode ports.
  assign o_rs_data = (wr_en && i_rs_addr == i_addr_reg_dst) ? o_wb_data : regs[i_rs_addr];
  assign o_rt_data = (wr_en && i_rt_addr == i_addr_reg_dst) ? o_wb_data : regs[i_rt_addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      idx <= '0;
    end else begin
      st  <= st_nxt;
      idx <= idx_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    idx_nxt = idx;
    case (st)
      IDLE: if (i_dump_req) begin
        st_nxt  = DUMP;
        idx_nxt = '0;
      end
      DUMP: if (i_dump_ready) begin
        if (idx == ADDR_W'(NREGS - 1)) st_nxt = DONE;
        else                           idx_nxt = idx + ADDR_W'(1);
      end
      DONE: begin
        st_nxt  = IDLE;
        idx_nxt = '0;
      end
      default: begin
        st_nxt  = IDLE;
        idx_nxt = '0;
      end
    endcase
  end

  assign o_dump_valid = (st == DUMP);
  assign o_dump_done  = (st == DONE);
  assign o_dump_addr  = idx;
  assign o_dump_data  = regs[idx];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: mux priority, bypass, r0 / step gating, dump sequencing and reset abort.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_step;
  logic [31:0] i_output_mem, i_ALU_res, i_pc_to_reg;
  logic [4:0]  i_addr_reg_dst, i_rs_addr, i_rt_addr;
  logic        is_RegWrite, is_MemtoReg, is_write_pc;
  logic [31:0] o_rs_data, o_rt_data, o_wb_data;
  logic        i_dump_req, i_dump_ready;
  logic        o_dump_valid, o_dump_done;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .i_step(i_step),
    .i_output_mem(i_output_mem), .i_ALU_res(i_ALU_res), .i_pc_to_reg(i_pc_to_reg),
    .i_addr_reg_dst(i_addr_reg_dst), .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
    .is_write_pc(is_write_pc), .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_wb_data(o_wb_data),
    .i_dump_req(i_dump_req), .i_dump_ready(i_dump_ready), .o_dump_valid(o_dump_valid),
    .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data), .o_dump_done(o_dump_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; the following rising edge commits.
  task automatic write_reg(input logic [4:0] dst, input logic [31:0] val);
    i_step = 1'b1; is_RegWrite = 1'b1; is_write_pc = 1'b0; is_MemtoReg = 1'b0;
    i_addr_reg_dst = dst; i_ALU_res = val;
    @(negedge clk);
    is_RegWrite = 1'b0;
  endtask

  initial begin
    int exp_idx, stall, dones, words;
    rst = 1'b0; i_step = 1'b0; i_output_mem = '0; i_ALU_res = '0; i_pc_to_reg = '0;
    i_addr_reg_dst = '0; is_RegWrite = 1'b0; is_MemtoReg = 1'b0; is_write_pc = 1'b0;
    i_rs_addr = '0; i_rt_addr = '0; i_dump_req = 1'b0; i_dump_ready = 1'b0;

    // 1. reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i += 7) begin
      i_rs_addr = 5'(i); i_rt_addr = 5'(31 - i); #1;
      chk("rst_rs", o_rs_data, 32'h0);
      chk("rst_rt", o_rt_data, 32'h0);
    end
    chk("rst_valid", {31'b0, o_dump_valid}, 32'h0);
    chk("rst_done", {31'b0, o_dump_done}, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // 2. ALU write plus same-cycle bypass
    i_step = 1'b1; is_RegWrite = 1'b1; i_addr_reg_dst = 5'd5; i_ALU_res = 32'h1234;
    i_rs_addr = 5'd5; i_rt_addr = 5'd5; #1;
    chk("byp_rt", o_rt_data, 32'h1234);
    chk("byp_wb", o_wb_data, 32'h1234);
    @(negedge clk); is_RegWrite = 1'b0; #1;
    chk("wr5_rs", o_rs_data, 32'h1234);

    // 3. mux priority
    is_RegWrite = 1'b1; is_write_pc = 1'b1; is_MemtoReg = 1'b1; i_pc_to_reg = 32'h40;
    i_output_mem = 32'hAA; i_ALU_res = 32'h77; i_addr_reg_dst = 5'd31; #1;
    chk("mux_pc", o_wb_data, 32'h40);
    @(negedge clk); is_RegWrite = 1'b0; i_rs_addr = 5'd31; #1;
    chk("reg31_pc", o_rs_data, 32'h40);
    is_RegWrite = 1'b1; is_write_pc = 1'b0; #1;
    chk("mux_mem", o_wb_data, 32'hAA);
    @(negedge clk); is_RegWrite = 1'b0; is_MemtoReg = 1'b0; #1;
    chk("reg31_mem", o_rs_data, 32'hAA);
    i_rt_addr = 5'd6; #1;
    chk("alu_sel", o_wb_data, 32'h77);

    // 4. r0 discard and step gating
    is_RegWrite = 1'b1; i_addr_reg_dst = 5'd0; i_ALU_res = 32'hFFFF_FFFF; i_rs_addr = 5'd0; #1;
    chk("r0_byp", o_rs_data, 32'h0);
    @(negedge clk); #1;
    chk("r0_store", o_rs_data, 32'h0);
    i_step = 1'b0; i_addr_reg_dst = 5'd3; i_ALU_res = 32'h55; i_rt_addr = 5'd3; #1;
    chk("nostep_byp", o_rt_data, 32'h0);
    @(negedge clk); is_RegWrite = 1'b0; #1;
    chk("nostep_store", o_rt_data, 32'h0);

    // 5. full dump with a 3-cycle stall at index 7
    for (int k = 1; k < 32; k++) write_reg(5'(k), 32'(k * 32'h11));
    i_step = 1'b0;
    i_dump_req = 1'b1;
    @(negedge clk); i_dump_req = 1'b0;
    exp_idx = 0; stall = 0; dones = 0; words = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (o_dump_valid && o_dump_addr == 5'd7 && stall < 3) begin
        i_dump_ready = 1'b0; stall++;
      end else i_dump_ready = 1'b1;
      if (o_dump_valid && i_dump_ready) begin
        chk("dump_addr", {27'b0, o_dump_addr}, 32'(exp_idx));
        chk("dump_data", o_dump_data, 32'(exp_idx * 32'h11));
        exp_idx++; words++;
      end
      if (o_dump_done) begin
        dones++;
        chk("done_valid", {31'b0, o_dump_valid}, 32'h0);
      end
      @(negedge clk);
    end
    chk("dump_words", 32'(words), 32'd32);
    chk("dump_stall", 32'(stall), 32'd3);
    chk("dump_dones", 32'(dones), 32'd1);

    // 6. reset mid-dump at index 12
    i_dump_ready = 1'b1; i_dump_req = 1'b1;
    @(negedge clk); i_dump_req = 1'b0;
    for (int c = 0; c < 40 && !(o_dump_valid && o_dump_addr == 5'd12); c++) @(negedge clk);
    chk("abort_reach12", {27'b0, o_dump_addr}, 32'd12);
    rst = 1'b0; #1;
    chk("abort_valid", {31'b0, o_dump_valid}, 32'h0);
    i_rs_addr = 5'd5; i_rt_addr = 5'd31; #1;
    chk("abort_rs", o_rs_data, 32'h0);
    chk("abort_rt", o_rt_data, 32'h0);
    @(negedge clk); rst = 1'b1;
    dones = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (o_dump_done || o_dump_valid) dones++;
    end
    chk("abort_quiet", 32'(dones), 32'd0);
    i_dump_req = 1'b1;
    @(negedge clk); i_dump_req = 1'b0; #1;
    chk("restart_valid", {31'b0, o_dump_valid}, 32'h1);
    chk("restart_addr", {27'b0, o_dump_addr}, 32'd0);
    @(negedge clk); #1;
    chk("restart_addr1", {27'b0, o_dump_addr}, 32'd1);
    chk("restart_data1", o_dump_data, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
